com_bus_arbiter: RTL and testbench

COM_BUS_ARBITER -- requirements
Module: com_bus_arbiter

---
 rtl/com_bus_arb_pkg.sv | 12 +
 rtl/rr_arbiter.sv | 49 ++++
 rtl/com_bus_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_com_bus_arbiter.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/com_bus_arb_pkg.sv
// Shared defaults and channel state type for the common-bus arbiter.
package com_bus_arb_pkg;

  localparam int unsigned NUM_REQ_DEF        = 8;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 256;

  typedef enum logic {
    ARB_IDLE,
    ARB_GRANT
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// N-way round-robin picker: scans ascending from the pointer, skipping masked
// requesters; the pointer moves to winner+1 only when the caller takes the winner.
module rr_arbiter
  import com_bus_arb_pkg::*;
#(
  parameter int unsigned N = NUM_REQ_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic [N-1:0] mask,
  input  logic         advance,
  output logic [N-1:0] gnt_c,
  output logic         any_c
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;
  logic [PW-1:0] idx_c;
  logic [N-1:0]  elig_c;

  // First eligible requester at or after the pointer, wrapping N-1 -> 0
  always_comb begin
    elig_c = req & ~mask;
    gnt_c  = '0;
    any_c  = 1'b0;
    ptr_d  = ptr_q;
    idx_c  = '0;
    for (int i = 0; i < int'(N); i++) begin
      idx_c = PW'((int'(ptr_q) + i) % int'(N));
      if (!any_c && elig_c[idx_c]) begin
        any_c        = 1'b1;
        gnt_c[idx_c] = 1'b1;
        ptr_d        = PW'((int'(idx_c) + 1) % int'(N));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (advance) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/com_bus_arbiter.sv
// Two-channel common-bus arbiter (proc and snoop, memory as lowest-priority snoop
// requester). Optional grant timeout with holder lockout under COM_BUS_ARB_TIMEOUT_EN.
module com_bus_arbiter
  import com_bus_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = NUM_REQ_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] Com_Bus_Req_proc,
  input  logic [NUM_REQ-1:0] Com_Bus_Req_snoop,
  input  logic               Mem_snoop_req,
  output logic [NUM_REQ-1:0] Com_Bus_Gnt_proc,
  output logic [NUM_REQ-1:0] Com_Bus_Gnt_snoop,
  output logic               Mem_snoop_gnt,
  output logic               Bus_busy,
  output logic               Arb_timeout
);

  localparam int unsigned N  = NUM_REQ;
  localparam int unsigned SW = NUM_REQ + 1;

  if (NUM_REQ < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("com_bus_arbiter: NUM_REQ must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  arb_state_e    p_state_q, p_state_d;
  logic [N-1:0]  p_gnt_q, p_gnt_d;
  logic [N-1:0]  p_lock_q, p_mask_c, p_win_c;
  logic          p_any_c, p_rel_c, p_to_c, p_adv_c;

  arb_state_e    s_state_q, s_state_d;
  logic [SW-1:0] s_req_c, s_gnt_q, s_gnt_d;
  logic [SW-1:0] s_lock_q, s_mask_c, s_win_c;
  logic [N-1:0]  s_rr_win_c;
  logic          s_rr_any_c, s_rr_adv_c, s_mem_elig_c;
  logic          s_any_c, s_rel_c, s_to_c, s_adv_c;

  // Proc channel: holder is masked so a release edge hands over to someone else
  assign p_mask_c = p_lock_q | p_gnt_q;
  assign p_rel_c  = (p_state_q == ARB_GRANT) &&
                    (((p_gnt_q & Com_Bus_Req_proc) == '0) || p_to_c);

  rr_arbiter #(.N(N)) u_rr_proc (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (Com_Bus_Req_proc),
    .mask    (p_mask_c),
    .advance (p_adv_c),
    .gnt_c   (p_win_c),
    .any_c   (p_any_c)
  );

  always_comb begin
    p_state_d = p_state_q;
    p_gnt_d   = p_gnt_q;
    p_adv_c   = 1'b0;
    case (p_state_q)
      ARB_IDLE: begin
        if (p_any_c) begin
          p_state_d = ARB_GRANT;
          p_gnt_d   = p_win_c;
          p_adv_c   = 1'b1;
        end
      end
      ARB_GRANT: begin
        if (p_rel_c) begin
          if (p_any_c) begin
            p_gnt_d = p_win_c;
            p_adv_c = 1'b1;
          end else begin
            p_state_d = ARB_IDLE;
            p_gnt_d   = '0;
          end
        end
      end
      default: begin
        p_state_d = ARB_IDLE;
        p_gnt_d   = '0;
      end
    endcase
  end

  // Snoop channel: bit N of the vector is the memory requester
  assign s_req_c      = {Mem_snoop_req, Com_Bus_Req_snoop};
  assign s_mask_c     = s_lock_q | s_gnt_q;
  assign s_mem_elig_c = Mem_snoop_req & ~s_mask_c[N];
  assign s_any_c      = s_rr_any_c | s_mem_elig_c;
  assign s_win_c      = s_rr_any_c ? {1'b0, s_rr_win_c} : {s_mem_elig_c, {N{1'b0}}};
  assign s_rr_adv_c   = s_adv_c & s_rr_any_c;
  assign s_rel_c      = (s_state_q == ARB_GRANT) &&
                        (((s_gnt_q & s_req_c) == '0) || s_to_c);

  rr_arbiter #(.N(N)) u_rr_snoop (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (Com_Bus_Req_snoop),
    .mask    (s_mask_c[N-1:0]),
    .advance (s_rr_adv_c),
    .gnt_c   (s_rr_win_c),
    .any_c   (s_rr_any_c)
  );

  always_comb begin
    s_state_d = s_state_q;
    s_gnt_d   = s_gnt_q;
    s_adv_c   = 1'b0;
    case (s_state_q)
      ARB_IDLE: begin
        if (s_any_c) begin
          s_state_d = ARB_GRANT;
          s_gnt_d   = s_win_c;
          s_adv_c   = 1'b1;
        end
      end
      ARB_GRANT: begin
        if (s_rel_c) begin
          if (s_any_c) begin
            s_gnt_d = s_win_c;
            s_adv_c = 1'b1;
          end else begin
            s_state_d = ARB_IDLE;
            s_gnt_d   = '0;
          end
        end
      end
      default: begin
        s_state_d = ARB_IDLE;
        s_gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_state_q <= ARB_IDLE;
      p_gnt_q   <= '0;
      s_state_q <= ARB_IDLE;
      s_gnt_q   <= '0;
    end else begin
      p_state_q <= p_state_d;
      p_gnt_q   <= p_gnt_d;
      s_state_q <= s_state_d;
      s_gnt_q   <= s_gnt_d;
    end
  end

`ifdef COM_BUS_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  // Counts visible grant cycles; restarts at 1 on every new grant
  logic [CW-1:0] p_cnt_q, s_cnt_q;

  assign p_to_c = (p_state_q == ARB_GRANT) && ((p_gnt_q & Com_Bus_Req_proc) != '0) &&
                  (p_cnt_q == CW'(TIMEOUT_CYCLES));
  assign s_to_c = (s_state_q == ARB_GRANT) && ((s_gnt_q & s_req_c) != '0) &&
                  (s_cnt_q == CW'(TIMEOUT_CYCLES));

  // Lockout bit clears on the first edge the locked requester's line is low
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_cnt_q     <= '0;
      s_cnt_q     <= '0;
      p_lock_q    <= '0;
      s_lock_q    <= '0;
      Arb_timeout <= 1'b0;
    end else begin
      p_cnt_q     <= p_adv_c ? CW'(1) :
                     (p_state_d == ARB_GRANT) ? p_cnt_q + CW'(1) : '0;
      s_cnt_q     <= s_adv_c ? CW'(1) :
                     (s_state_d == ARB_GRANT) ? s_cnt_q + CW'(1) : '0;
      p_lock_q    <= (p_lock_q & Com_Bus_Req_proc) | (p_to_c ? p_gnt_q : '0);
      s_lock_q    <= (s_lock_q & s_req_c) | (s_to_c ? s_gnt_q : '0);
      Arb_timeout <= p_to_c | s_to_c;
    end
  end
`else
  assign p_to_c      = 1'b0;
  assign s_to_c      = 1'b0;
  assign p_lock_q    = '0;
  assign s_lock_q    = '0;
  assign Arb_timeout = 1'b0;
`endif

  assign Com_Bus_Gnt_proc  = p_gnt_q;
  assign Com_Bus_Gnt_snoop = s_gnt_q[N-1:0];
  assign Mem_snoop_gnt     = s_gnt_q[N];
  assign Bus_busy          = |p_gnt_q;

endmodule

// File: tb/tb_com_bus_arbiter.sv
// Directed scoreboard bench for com_bus_arbiter; the timeout scenario runs when
// COM_BUS_ARB_TIMEOUT_EN is defined, the hold-forever scenario otherwise.
module tb_com_bus_arbiter;

  typedef struct packed {
    logic [7:0] proc;
    logic [7:0] snoop;
    logic       mem;
    logic       busy;
    logic       to;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req_proc, req_snoop;
  logic       mem_req;
  logic [7:0] gnt_proc, gnt_snoop;
  logic       mem_gnt, bus_busy, arb_timeout;

  obs_t  exp_q[$];
  string tag_q[$];
  int    n_vec = 0;
  int    n_err = 0;

  always #5 clk = ~clk;

`ifdef COM_BUS_ARB_TIMEOUT_EN
  localparam int unsigned TB_TIMEOUT = 4;
`else
  localparam int unsigned TB_TIMEOUT = 256;
`endif

  com_bus_arbiter #(.NUM_REQ(8), .TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .Com_Bus_Req_proc  (req_proc),
    .Com_Bus_Req_snoop (req_snoop),
    .Mem_snoop_req     (mem_req),
    .Com_Bus_Gnt_proc  (gnt_proc),
    .Com_Bus_Gnt_snoop (gnt_snoop),
    .Mem_snoop_gnt     (mem_gnt),
    .Bus_busy          (bus_busy),
    .Arb_timeout       (arb_timeout)
  );

  // Push the expectation for the coming edge, then pop and compare after it
  task automatic cyc(input string tag, input logic [7:0] p, input logic [7:0] s,
                     input logic m, input logic t);
    obs_t  e, o;
    string tg;
    exp_q.push_back('{proc: p, snoop: s, mem: m, busy: |p, to: t});
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    e  = exp_q.pop_front();
    tg = tag_q.pop_front();
    o  = '{proc: gnt_proc, snoop: gnt_snoop, mem: mem_gnt, busy: bus_busy, to: arb_timeout};
    n_vec++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h (proc/snoop/mem/busy/to)", tg, o, e);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, observed time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    req_proc  = '0;
    req_snoop = '0;
    mem_req   = 1'b0;
    cyc("reset0", 8'h00, 8'h00, 1'b0, 1'b0);
    cyc("reset1", 8'h00, 8'h00, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Two requesters, zero-bubble handover
    req_proc = 8'h05;
    cyc("p05_first", 8'h01, 8'h00, 1'b0, 1'b0);
    cyc("p05_hold", 8'h01, 8'h00, 1'b0, 1'b0);
    req_proc = 8'h04;
    cyc("p05_handover", 8'h04, 8'h00, 1'b0, 1'b0);
    req_proc = 8'h00;
    cyc("p05_idle", 8'h00, 8'h00, 1'b0, 1'b0);

    // Re-zero the pointer, then full round-robin with wrap back to 0
    rst_n = 1'b0;
    cyc("rr_reset", 8'h00, 8'h00, 1'b0, 1'b0);
    rst_n    = 1'b1;
    req_proc = 8'hFF;
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 3; j++) begin
        cyc($sformatf("rr_k%0d_j%0d", k, j), 8'(1 << k), 8'h00, 1'b0, 1'b0);
        if (j == 0 && k > 0) req_proc[k-1] = 1'b1;
      end
      req_proc[k] = 1'b0;
    end
    cyc("rr_wrap", 8'h01, 8'h00, 1'b0, 1'b0);
    req_proc[7] = 1'b1;
    cyc("rr_wrap_hold", 8'h01, 8'h00, 1'b0, 1'b0);
    req_proc = 8'h00;
    cyc("rr_idle", 8'h00, 8'h00, 1'b0, 1'b0);

    // Snoop beats memory; proc channel runs alongside untouched
    req_proc  = 8'h02;
    req_snoop = 8'h10;
    mem_req   = 1'b1;
    cyc("sn_cache_wins", 8'h02, 8'h10, 1'b0, 1'b0);
    req_snoop = 8'h00;
    cyc("sn_mem_next", 8'h02, 8'h00, 1'b1, 1'b0);
    cyc("sn_mem_hold", 8'h02, 8'h00, 1'b1, 1'b0);
    mem_req  = 1'b0;
    req_proc = 8'h00;
    cyc("sn_idle", 8'h00, 8'h00, 1'b0, 1'b0);

    // Memory holder is not preempted by a late cache request
    mem_req = 1'b1;
    cyc("mem_alone", 8'h00, 8'h00, 1'b1, 1'b0);
    req_snoop = 8'h01;
    cyc("mem_no_preempt", 8'h00, 8'h00, 1'b1, 1'b0);
    mem_req = 1'b0;
    cyc("mem_to_cache", 8'h00, 8'h01, 1'b0, 1'b0);
    req_snoop = 8'h00;
    cyc("sn_idle2", 8'h00, 8'h00, 1'b0, 1'b0);

    // Reset mid-grant, then pointer restarts at 0
    req_proc = 8'h08;
    cyc("pre_rst_grant", 8'h08, 8'h00, 1'b0, 1'b0);
    cyc("pre_rst_hold", 8'h08, 8'h00, 1'b0, 1'b0);
    rst_n = 1'b0;
    cyc("mid_grant_rst", 8'h00, 8'h00, 1'b0, 1'b0);
    rst_n    = 1'b1;
    req_proc = 8'h88;
    cyc("post_rst_88", 8'h08, 8'h00, 1'b0, 1'b0);
    cyc("post_rst_hold", 8'h08, 8'h00, 1'b0, 1'b0);
    req_proc = 8'h80;
    cyc("post_rst_80", 8'h80, 8'h00, 1'b0, 1'b0);
    cyc("post_rst_80b", 8'h80, 8'h00, 1'b0, 1'b0);
    req_proc = 8'h00;
    cyc("post_rst_idle", 8'h00, 8'h00, 1'b0, 1'b0);

`ifdef COM_BUS_ARB_TIMEOUT_EN
    // Timeout of 4: forced handover, lockout until request is dropped
    rst_n = 1'b0;
    cyc("to_reset", 8'h00, 8'h00, 1'b0, 1'b0);
    rst_n    = 1'b1;
    req_proc = 8'h03;
    for (int i = 0; i < 4; i++) cyc($sformatf("to_g0_%0d", i), 8'h01, 8'h00, 1'b0, 1'b0);
    cyc("to_pulse0", 8'h02, 8'h00, 1'b0, 1'b1);
    for (int i = 1; i < 4; i++) cyc($sformatf("to_g1_%0d", i), 8'h02, 8'h00, 1'b0, 1'b0);
    cyc("to_pulse1", 8'h00, 8'h00, 1'b0, 1'b1);
    cyc("to_locked", 8'h00, 8'h00, 1'b0, 1'b0);
    req_proc = 8'h02;
    cyc("to_drop0", 8'h00, 8'h00, 1'b0, 1'b0);
    req_proc = 8'h03;
    cyc("to_regain0", 8'h01, 8'h00, 1'b0, 1'b0);
    req_proc = 8'h00;
    cyc("to_idle", 8'h00, 8'h00, 1'b0, 1'b0);
`else
    // No timeout: a single holder keeps the bus indefinitely
    req_proc = 8'h01;
    for (int i = 0; i < 1000; i++) cyc("hold_forever", 8'h01, 8'h00, 1'b0, 1'b0);
    req_proc = 8'h00;
    cyc("hold_release", 8'h00, 8'h00, 1'b0, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
